sprite_store: RTL
=================

# sprite_store

Double-banked 64x64 pixel memory that answers the sprite drawing stage's `pixel_addr` requests with `rgb_pixel`, one registered cycle later. It sits beside the rectangle/sprite overlay in the VGA pipeline. A byte-stream loader (UART receiver or similar) fills the hidden bank while the visible bank is being read. The banks swap on the next vsync rising edge after a complete image has been written, so the display never shows a partially loaded sprite.

## Interface
- `ADDR_WIDTH`, 12: pixel address width; `[11:6]` = row, `[5:0]` = column; depth 2^ADDR_WIDTH per bank.
- `RGB_WIDTH`, 12: pixel width, 4:4:4 RGB.
- `clk`  in  1  pixel clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pixel_addr`  in  12  read address from the sprite drawing stage.
- `rgb_pixel`  out  12  pixel at `pixel_addr` from the front bank, registered.
- `vsync_in`  in  1  frame sync from the timing chain; its rising edge is the swap point.
- `load_start`  in  1  one-cycle pulse that begins a new image load.
- `load_data`  in  8  loader byte.
- `load_valid`  in  1  `load_data` is valid this cycle.
- `load_ready`  out  1  block accepts a byte this cycle; transfer occurs when `load_valid && load_ready`.
- `load_busy`  out  1  a load is in progress or a swap is pending.
- `front_bank`  out  1  index of the bank currently being displayed.
- `swap_pulse`  out  1  one-cycle pulse in the cycle after the banks swap.

## Operation
- Storage:
  - Two banks of 4096 x 12 bits each.
  - Reads always use the `front_bank` bank.
  - Writes always use bank `~front_bank`.
  - Reads and writes never target the same bank, so there is no read/write conflict.
- Read path: `rgb_pixel <= mem[front_bank][pixel_addr]` on every clock, unconditionally.
- Pixel packing:
  - The first byte supplies R in bits `[3:0]`; bits `[7:4]` are ignored.
  - The second byte supplies `{G,B}`.
  - The stored word is `{byte0[3:0], byte1[7:0]}`.
- Write pointer: 12 bits, row-major (address = row*64 + col).
- FSM states: IDLE, HI, LO, PEND.
  - IDLE:
    - `load_ready`=0, `load_busy`=0.
    - On `load_start`: write pointer := 0, go to HI.
  - HI:
    - `load_ready`=1.
    - On a transfer: latch `load_data[3:0]`, go to LO.
  - LO:
    - `load_ready`=1.
    - On a transfer: write `{nibble, load_data}` at the write pointer.
    - If the pointer is 4095, go to PEND; otherwise increment the pointer and go to HI.
  - PEND:
    - `load_ready`=0.
    - On a vsync rising edge: toggle `front_bank`, go to IDLE.
  - `load_busy` = 1 in HI, LO and PEND.
- `load_start` while in HI or LO restarts the load: pointer := 0, state HI, any latched nibble discarded. Words already written stay in the back bank.
- `load_start` while in PEND is ignored.
- `load_valid` is ignored whenever `load_ready`=0.
- Vsync edge detect:
  - `vsync_q` is `vsync_in` registered.
  - Edge = `vsync_in && !vsync_q`.
  - An edge outside PEND has no effect.

## Timing
- Read latency is exactly 1 cycle: an address presented before edge N appears on `rgb_pixel` after edge N. This matches the consumer, which registers `pixel_addr` one stage before it samples `rgb_pixel`.
- Swap edge:
  - The read launched at the swap edge still uses the old bank.
  - The first read launched after the swap edge uses the new bank.
  - `front_bank` and `swap_pulse` change at the swap edge; `swap_pulse` is high for the one following cycle.
- Last pixel and vsync edge in the same cycle:
  - The write completes and the state goes to PEND.
  - The swap waits for the next vsync rising edge.
- Write latency: a transferred second byte is in memory at the following edge. The data only becomes visible after the swap.
- Reset values (rst_n low, asynchronous):
  - `rgb_pixel`=0, `load_ready`=0, `load_busy`=0, `front_bank`=0, `swap_pulse`=0.
  - State IDLE, pointer 0, `vsync_q`=0.
- Memory contents are not cleared by reset.
- Reset mid-load or in PEND abandons the load; the bank selection returns to 0.
- Throughput: one byte per cycle when `load_valid` is held high, i.e. 8192 cycles for a full image.

## Test plan
- **Reset:** assert `rst_n`=0 mid-LO with `vsync_in` toggling. Required: all outputs 0, state IDLE; a subsequent `load_start` gives `load_ready`=1 one cycle later.
- **Full load and swap:**
  - Load 8192 bytes where pixel k = k[11:0] (byte0=k[11:8], byte1=k[7:0]) with `load_valid` held high.
  - Required: `load_ready` drops after byte 8192, `load_busy`=1.
  - On the next vsync rise: `front_bank`=1, `swap_pulse` high for 1 cycle.
  - Then `pixel_addr`=0x07F reads 0x07F and `pixel_addr`=0xFFF reads 0xFFF.
- **Read latency:** sweep `pixel_addr` 0,1,2,... every cycle. Required: `rgb_pixel` equals the previous cycle's address data, with no gaps.
- **Swap boundary:** after a second load with pattern 0xABC, present `pixel_addr`=5 at the swap edge and again the cycle after. Required: old-bank word, then 0xABC.
- **Backpressure and restart:**
  - Drive `load_valid` randomly with 50% duty, pulse `load_start` after 100 bytes, then complete the load.
  - Required: the image matches the post-restart data only.
  - `load_start` while in PEND is ignored.
- **Coincident last byte and vsync:** make the last-byte transfer coincide with a vsync rising edge. Required: no swap at that edge; the swap occurs at the next vsync edge.

Source files
------------

// File: rtl/sprite_store.sv
// Double-banked sprite pixel memory: the front bank serves registered reads while a
// byte-stream loader fills the back bank; banks swap on the first vsync rise after a full image.
module sprite_store #(
  parameter int ADDR_WIDTH = 12,
  parameter int RGB_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pixel_addr,
  output logic [RGB_WIDTH-1:0]  rgb_pixel,
  input  logic                  vsync_in,
  input  logic                  load_start,
  input  logic [7:0]            load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  front_bank,
  output logic                  swap_pulse
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;
  localparam logic [1:0] ST_PEND = 2'd3;

  logic [1:0]            state_reg,  state_next;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [3:0]            nibble_reg, nibble_next;
  logic                  front_reg,  front_next;
  logic                  swap_reg,   swap_next;
  logic                  vsync_q;

  logic                  xfer;
  logic                  vsync_edge;
  logic                  mem_we;
  logic [RGB_WIDTH-1:0]  wr_word;

  // Both banks live in one array; the top address bit selects the bank.
  logic [RGB_WIDTH-1:0]  mem [0:2*DEPTH-1];

  assign load_ready = (state_reg == ST_HI) || (state_reg == ST_LO);
  assign load_busy  = (state_reg != ST_IDLE);
  assign front_bank = front_reg;
  assign swap_pulse = swap_reg;

  assign xfer       = load_valid && load_ready;
  assign vsync_edge = vsync_in && !vsync_q;
  // A restart pulse takes priority over a coincident second byte.
  assign mem_we     = xfer && (state_reg == ST_LO) && !load_start;
  assign wr_word    = RGB_WIDTH'({nibble_reg, load_data});

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    nibble_next = nibble_reg;
    front_next  = front_reg;
    swap_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (load_start) begin
          wr_ptr_next = '0;
          state_next  = ST_HI;
        end
      end
      ST_HI: begin
        if (load_start) begin
          wr_ptr_next = '0;
          nibble_next = '0;
        end else if (xfer) begin
          nibble_next = load_data[3:0];
          state_next  = ST_LO;
        end
      end
      ST_LO: begin
        if (load_start) begin
          wr_ptr_next = '0;
          nibble_next = '0;
          state_next  = ST_HI;
        end else if (xfer) begin
          if (wr_ptr_reg == '1) begin
            state_next = ST_PEND;
          end else begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
            state_next  = ST_HI;
          end
        end
      end
      ST_PEND: begin
        if (vsync_edge) begin
          front_next = ~front_reg;
          swap_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      wr_ptr_reg <= '0;
      nibble_reg <= '0;
      front_reg  <= 1'b0;
      swap_reg   <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      nibble_reg <= nibble_next;
      front_reg  <= front_next;
      swap_reg   <= swap_next;
      vsync_q    <= vsync_in;
    end
  end

  // Memory contents survive reset; only the write port is clocked here.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{~front_reg, wr_ptr_reg}] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_pixel <= '0;
    end else begin
      rgb_pixel <= mem[{front_reg, pixel_addr}];
    end
  end

endmodule
